// File: rtl/imm_encoder.sv
// imm_encoder
// Streaming immediate packer. Each accepted request scatters a 32-bit
// immediate into the bit positions of one IcyRisc immediate format
// (I/S/B/U/J) on top of a base instruction word. The result is queued in a
// DEPTH-entry FIFO behind a valid/ready handshake. Every output is
// registered, so there is no combinational path from any input to any output.
//
// Optional feature macro: IMM_ENC_CHECK_EN
//   defined   - representability checks are built. Each FIFO entry carries
//               an error bit, and err_cnt counts erroneous pushes.
//   undefined - no check logic is built and entries are 32 bits wide.
//               out_err and err_cnt read as zero.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of FIFO contents (err_cnt is kept)
//   in_valid   request valid
//   in_ready   FIFO not full (registered)
//   imm_ctrl   format: 0=I 1=S 2=B 3=U 4=J, 5..7 illegal
//   imm        immediate value
//   base       instruction word supplying all non-immediate bits
//   out_valid  FIFO non-empty (registered)
//   out_ready  consumer accepts the head entry
//   instr      packed instruction at the FIFO head (registered)
//   out_err    head entry was not representable (registered)
//   level      current occupancy
//   err_cnt    saturating count of erroneous pushes
module imm_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 imm_ctrl,
    input  logic [31:0]                imm,
    input  logic [31:0]                base,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                instr,
    output logic                       out_err,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef IMM_ENC_CHECK_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

    // Scatter the immediate into the format's positions; other bits come from base.
    function automatic logic [31:0] pack_imm(input logic [2:0] ctrl,
                                             input logic [31:0] v,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = b;
        case (ctrl)
            3'd0: r[31:20] = v[11:0];
            3'd1: begin
                r[31:25] = v[11:5];
                r[11:7]  = v[4:0];
            end
            3'd2: begin
                r[31]    = v[11];
                r[7]     = v[10];
                r[30:25] = v[9:4];
                r[11:8]  = v[3:0];
            end
            3'd3: r[31:12] = v[31:12];
            3'd4: begin
                r[31]    = v[19];
                r[19:12] = v[18:11];
                r[20]    = v[10];
                r[30:21] = v[9:0];
            end
            default: r = b;
        endcase
        return r;
    endfunction

`ifdef IMM_ENC_CHECK_EN
    // True when the immediate cannot be recovered exactly by the decoder.
    function automatic logic imm_bad(input logic [2:0] ctrl, input logic [31:0] v);
        logic bad;
        case (ctrl)
            3'd0, 3'd1, 3'd2: bad = !((v[31:11] == 21'h000000) || (v[31:11] == 21'h1FFFFF));
            3'd3:             bad = (v[11:0] != 12'h000);
            3'd4:             bad = !((v[31:19] == 13'h0000) || (v[31:19] == 13'h1FFF));
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_r;
    logic [EW-1:0] head_nxt_s;
    logic [AW-1:0] wr_r;
    logic [AW-1:0] rd_r;
    logic [AW-1:0] wr_nxt_s;
    logic [AW-1:0] rd_nxt_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          push_s;
    logic          pop_s;

    // Build the FIFO entry for the current request.
    always_comb begin
`ifdef IMM_ENC_CHECK_EN
        entry_s = {imm_bad(imm_ctrl, imm), pack_imm(imm_ctrl, imm, base)};
`else
        entry_s = pack_imm(imm_ctrl, imm, base);
`endif
    end

    // Handshakes and next-state values for pointers, occupancy and head.
    always_comb begin
        push_s      = in_valid && in_ready_r;
        pop_s       = out_valid_r && out_ready;
        level_nxt_s = level_r + LW'(push_s) - LW'(pop_s);
        if (push_s) begin
            wr_nxt_s = wr_r + PTR_ONE;
        end else begin
            wr_nxt_s = wr_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_r;
        end
        // The next head is either the entry written this cycle (it lands
        // exactly at the new read pointer) or what memory already holds there.
        if (level_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (push_s && (wr_r == rd_nxt_s)) begin
            head_nxt_s = entry_s;
        end else begin
            head_nxt_s = mem[rd_nxt_s];
        end
    end

    // Entry storage; a push in a flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem[wr_r] <= entry_s;
        end
    end

    // Pointer, occupancy, handshake and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r        <= '0;
            rd_r        <= '0;
            level_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
        end else if (flush) begin
            wr_r        <= '0;
            rd_r        <= '0;
            level_r     <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
        end else begin
            wr_r        <= wr_nxt_s;
            rd_r        <= rd_nxt_s;
            level_r     <= level_nxt_s;
            in_ready_r  <= (level_nxt_s < LEVEL_MAX);
            out_valid_r <= (level_nxt_s != '0);
            head_r      <= head_nxt_s;
        end
    end

`ifdef IMM_ENC_CHECK_EN
    logic [15:0] err_cnt_r;

    // Saturating error counter; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 16'h0000;
        end else if (push_s && !flush && entry_s[32] && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end
    end

    assign out_err = head_r[32];
    assign err_cnt = err_cnt_r;
`else
    assign out_err = 1'b0;
    assign err_cnt = 16'h0000;
`endif

    assign instr     = head_r[31:0];
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed literal cases, then randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_imm_encoder;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    imm_ctrl;
    logic [31:0]   imm;
    logic [31:0]   base;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic          out_err;
    logic [LW-1:0] level;
    logic [15:0]   err_cnt;

    imm_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .imm_ctrl(imm_ctrl), .imm(imm), .base(base),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .out_err(out_err), .level(level), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        err;
        logic [2:0]  fmt;
        logic [31:0] v;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt;
    int          errors = 0;
    int          checks = 0;
    int unsigned saved_cnt;

    // Expected encoding written as field concatenations, MSB first.
    function automatic logic [31:0] model_pack(input logic [2:0] f, input logic [31:0] v, input logic [31:0] b);
        case (f)
            3'd0:    return {v[11:0], b[19:0]};
            3'd1:    return {v[11:5], b[24:12], v[4:0], b[6:0]};
            3'd2:    return {v[11], v[9:4], b[24:12], v[3:0], v[10], b[6:0]};
            3'd3:    return {v[31:12], b[11:0]};
            3'd4:    return {v[19], v[9:0], v[10], v[18:11], b[11:0]};
            default: return b;
        endcase
    endfunction

    // Representability from numeric ranges.
    function automatic logic model_bad(input logic [2:0] f, input logic [31:0] v);
        int s;
        s = int'(v);
        case (f)
            3'd0, 3'd1, 3'd2: return !(s >= -2048 && s <= 2047);
            3'd3:             return (v % 32'd4096) != 32'd0;
            3'd4:             return !(s >= -524288 && s <= 524287);
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic exp_err(input logic [2:0] f, input logic [31:0] v);
`ifdef IMM_ENC_CHECK_EN
        return model_bad(f, v);
`else
        return 1'b0;
`endif
    endfunction

    // Core-side decoder: must return the original immediate.
    function automatic logic [31:0] decode(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
            3'd3:    return {i[31:12], 12'h000};
            3'd4:    return {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]};
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic push;
        logic pop;
        ent_t e;
        @(posedge clk);
        push = in_valid && (q.size() < DEPTH);
        pop  = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.ins = model_pack(imm_ctrl, imm, base);
                e.err = exp_err(imm_ctrl, imm);
                e.fmt = imm_ctrl;
                e.v   = imm;
                q.push_back(e);
                if (e.err && m_cnt < 32'hFFFF) m_cnt++;
            end
        end
        #1;
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("out_valid", out_valid, q.size() > 0);
        chk("level", level, q.size());
        chk("err_cnt", err_cnt, m_cnt);
        if (q.size() > 0) begin
            chk("instr", instr, q[0].ins);
            chk("out_err", out_err, q[0].err);
            if (!model_bad(q[0].fmt, q[0].v)) chk("roundtrip", decode(q[0].fmt, instr), q[0].v);
        end
    endtask

    task automatic push_one(input logic [2:0] f, input logic [31:0] v, input logic [31:0] b);
        in_valid = 1'b1; imm_ctrl = f; imm = v; base = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_out_err"}, out_err, 1'b0);
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h000007FE + 32'($urandom_range(0, 2))
                                                        : 32'hFFFFF7FF + 32'($urandom_range(0, 2));
            3:       return $urandom & 32'hFFFFF000;
            4:       return 32'($urandom_range(0, 1048575)) - 32'd524288;
            default: return ($urandom_range(0, 1) != 0) ? 32'h0007FFFF + 32'($urandom_range(0, 1))
                                                        : 32'hFFF7FFFF + 32'($urandom_range(0, 1));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm_ctrl = 3'd0; imm = 32'h0; base = 32'h0; m_cnt = 0;
        #12;
        chk_idle("reset");
        chk("reset_err_cnt", err_cnt, 16'h0);
        rst_n = 1'b1;

        // Literal pins for the model.
        push_one(3'd0, 32'hFFFFFFFF, 32'h00000013);
        chk("lit_i", instr, 32'hFFF00013);
        chk("lit_i_err", out_err, 1'b0);
        pop_one();
        push_one(3'd2, 32'hFFFFF800, 32'h00000063);
        chk("lit_b", instr, 32'h80000063);
        pop_one();
        push_one(3'd4, 32'h0007FFFF, 32'h0000006F);
        chk("lit_j", instr, 32'h7FFFF06F);
        pop_one();
        push_one(3'd3, 32'h12345678, 32'h00000037);
        chk("lit_u", instr, 32'h12345037);
`ifdef IMM_ENC_CHECK_EN
        chk("lit_u_err", out_err, 1'b1);
        chk("lit_u_cnt", err_cnt, 16'd1);
`else
        chk("lit_u_err", out_err, 1'b0);
`endif
        pop_one();
        push_one(3'd6, 32'h00000001, 32'hDEADBEEF);
        chk("lit_ill", instr, 32'hDEADBEEF);
`ifdef IMM_ENC_CHECK_EN
        chk("lit_ill_cnt", err_cnt, 16'd2);
`else
        chk("lit_ill_cnt", err_cnt, 16'd0);
`endif
        pop_one();

        // Backpressure: fill, refused push, in-order drain.
        for (int i = 0; i < DEPTH; i++) push_one(3'd0, 32'(i * 3), 32'h00000013 + 32'(i << 7));
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_level", level, DEPTH);
        push_one(3'd1, 32'h00000055, 32'h00000023);
        chk("full_refused", level, DEPTH);
        out_ready = 1'b1;
        step();
        chk("ready_after_pop", in_ready, 1'b1);
        for (int i = 1; i < DEPTH; i++) step();
        out_ready = 1'b0;

        // Concurrent push/pop at level 2 across pointer wrap.
        push_one(3'd1, 32'hFFFFF801, 32'h00000023);
        push_one(3'd4, 32'hFFF80000, 32'h0000006F);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imm_ctrl = 3'($urandom_range(0, 4)); imm = rand_imm(); base = $urandom;
            step();
            chk("steady_level", level, 2);
        end
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;

        // Flush at level 3 with a simultaneous erroneous push.
        for (int i = 0; i < 3; i++) push_one(3'd3, 32'(i) << 12, 32'h00000037);
        saved_cnt = m_cnt;
        flush = 1'b1; in_valid = 1'b1; imm_ctrl = 3'd7; base = 32'h12345678;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_idle("flush");
        chk("flush_err_cnt", err_cnt, saved_cnt);

        // Asynchronous reset mid-stream.
        push_one(3'd5, 32'h0, 32'h00000033);
        push_one(3'd0, 32'h00000800, 32'h00000013);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        q.delete(); m_cnt = 0;
        chk_idle("async_rst");
        chk("async_rst_err_cnt", err_cnt, 16'h0);
        #10 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            imm_ctrl  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            imm       = rand_imm();
            base      = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
